// File: rtl/fetch_queue_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit_pkg
//   Shared definitions for the fetch front end: datapath widths, the HLT
//   instruction pattern, the fetch FSM state type and the fetch queue entry
//   layout ({pc, insn}, 96 bits).
// -----------------------------------------------------------------------------
package fetch_queue_unit_pkg;

    localparam int PC_SIZE       = 64;
    localparam int INSNBITS_SIZE = 32;

    // HLT: bits[31:21] = 11010100010, bits[4:0] = 0, everything else free.
    localparam logic [INSNBITS_SIZE-1:0] HLT_MASK  = 32'hFFE0_001F;
    localparam logic [INSNBITS_SIZE-1:0] HLT_MATCH = 32'hD440_0000;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_SIZE-1:0]       pc;
        logic [INSNBITS_SIZE-1:0] insn;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [INSNBITS_SIZE-1:0] word);
        return (word & HLT_MASK) == HLT_MATCH;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO with combinational head read (zero-cycle read latency,
//   no write-to-read bypass). A pop in the same cycle as a push frees a slot
//   first, so push+pop is accepted even when full. Flush empties the FIFO and
//   overrides push/pop.
// Ports:
//   in_clk, in_rst_n          clock, async active-low reset
//   in_push, in_wdata         write request and data
//   in_pop                    remove head (ignored when empty)
//   in_flush                  discard all entries
//   out_head                  head entry, 0 when empty
//   out_count                 number of valid entries
//   out_empty, out_full       status flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                       in_clk,
    input  logic                       in_rst_n,
    input  logic                       in_push,
    input  logic                       in_pop,
    input  logic                       in_flush,
    input  logic [WIDTH-1:0]           in_wdata,
    output logic [WIDTH-1:0]           out_head,
    output logic [$clog2(DEPTH+1)-1:0] out_count,
    output logic                       out_empty,
    output logic                       out_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign out_empty = (count_q == '0);
    assign out_full  = (count_q == CW'(DEPTH));
    assign out_count = count_q;
    assign out_head  = out_empty ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = in_pop & ~out_empty;
    assign do_push = in_push & (~out_full | do_pop);

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (in_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage has no reset; count_q gates every read, so stale contents
    // are never observed and the array maps onto plain RAM/flops without reset.
    always_ff @(posedge in_clk) begin
        if (do_push && !in_flush) mem_q[wr_ptr_q] <= in_wdata;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//   Fetch stage: drives PC to instruction memory, buffers returned words with
//   their PC in a small queue and presents the head to dispatch. Redirects
//   flush the queue and drop responses still in flight; fetching stops once
//   an HLT word has been enqueued.
// Ports:
//   in_clk, in_rst_n                   clock, async active-low reset
//   in_stall                           dispatch stall, no delivery this cycle
//   in_redirect_valid, in_redirect_pc  branch redirect
//   out_imem_req, out_imem_addr        imem request / word address (PC)
//   in_imem_gnt                        request accepted
//   in_imem_rvalid, in_imem_rdata      in-order response
//   out_fetch_insnbits, out_fetch_pc   head of queue (0 when empty)
//   out_fetch_done                     delivery strobe (pops the head)
//   out_halted                         HLT enqueued, fetch stopped
// -----------------------------------------------------------------------------
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int                 FQ_DEPTH        = 4,
    parameter int                 MAX_OUTSTANDING = 2,
    parameter logic [PC_SIZE-1:0] RESET_PC        = 64'h0
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic                     in_stall,
    input  logic                     in_redirect_valid,
    input  logic [PC_SIZE-1:0]       in_redirect_pc,
    output logic                     out_imem_req,
    output logic [PC_SIZE-1:0]       out_imem_addr,
    input  logic                     in_imem_gnt,
    input  logic                     in_imem_rvalid,
    input  logic [INSNBITS_SIZE-1:0] in_imem_rdata,
    output logic [INSNBITS_SIZE-1:0] out_fetch_insnbits,
    output logic [PC_SIZE-1:0]       out_fetch_pc,
    output logic                     out_fetch_done,
    output logic                     out_halted
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_t        state_q, state_d;
    logic [PC_SIZE-1:0]  pc_q, pc_d;
    logic [PC_SIZE-1:0]  rsp_pc_q, rsp_pc_d;   // PC of the next response to enqueue
    logic [OW-1:0]       outst_q, outst_d;
    logic [OW-1:0]       drop_q, drop_d;       // stale responses still to discard

    logic                grant, rsp_enq, rsp_drop, can_issue;
    logic [CW-1:0]       fq_count;
    logic                fq_empty, fq_full;
    fq_entry_t           fq_wdata, fq_head;

    assign grant    = out_imem_req & in_imem_gnt;
    assign rsp_drop = (drop_q != '0);
    assign rsp_enq  = in_imem_rvalid & ~in_redirect_valid & ~rsp_drop &
                      (state_q == FETCH_RUN);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state_q <= FETCH_RUN;
        else           state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: combinational blocks use blocking (=) and assign a default first,
    // so every path drives every variable and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (in_redirect_valid)
            state_d = FETCH_RUN;
        else if (state_q == FETCH_RUN && rsp_enq && is_hlt(in_imem_rdata))
            state_d = FETCH_HALTED;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_halted = (state_q == FETCH_HALTED);
        // The credit rule reserves a queue slot for every outstanding request;
        // the full flag is an explicit guard on top of it.
        can_issue  = (state_q == FETCH_RUN) && !in_redirect_valid && !fq_full &&
                     (int'(outst_q) < MAX_OUTSTANDING) &&
                     ((int'(fq_count) + int'(outst_q)) < FQ_DEPTH);
        // Reset state would otherwise satisfy the issue rule; keep req low.
        out_imem_req = in_rst_n & can_issue;
    end

    assign out_imem_addr = pc_q;

    // ---------------- PC / outstanding / drop bookkeeping ----------------
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;

        if (grant) pc_d = pc_q + 64'd4;

        unique case ({grant, in_imem_rvalid})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (in_imem_rvalid && rsp_drop) drop_d = drop_q - OW'(1);
        if (rsp_enq) rsp_pc_d = rsp_pc_q + 64'd4;

        // Redirect wins: no grant is possible this cycle, and a response
        // arriving now is discarded, so everything still in flight is stale.
        if (in_redirect_valid) begin
            pc_d     = in_redirect_pc & ~64'h3;
            rsp_pc_d = in_redirect_pc & ~64'h3;
            drop_d   = outst_q - OW'(in_imem_rvalid);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    // ---------------- Fetch queue and delivery ----------------
    assign fq_wdata = '{pc: rsp_pc_q, insn: in_imem_rdata};

    assign out_fetch_done     = ~fq_empty & ~in_stall & ~in_redirect_valid;
    assign out_fetch_insnbits = fq_head.insn;
    assign out_fetch_pc       = fq_head.pc;

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH ($bits(fq_entry_t))
    ) u_fifo (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_push   (rsp_enq),
        .in_pop    (out_fetch_done),
        .in_flush  (in_redirect_valid),
        .in_wdata  (fq_wdata),
        .out_head  (fq_head),
        .out_count (fq_count),
        .out_empty (fq_empty),
        .out_full  (fq_full)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
//   Randomized bench with an imem responder, a transaction-level reference
//   model (request records tagged with a redirect epoch) and a scoreboard of
//   expected deliveries. The stimulus process pushes expected entries when a
//   response is returned; a negedge monitor pops and compares on every
//   delivery and checks req/addr/halted/head against the model each cycle.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [63:0] RST_PC  = 64'h1000;
    localparam logic [31:0] HLT_W   = 32'hD440_0000;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_stall, in_redirect_valid;
    logic [63:0] in_redirect_pc;
    logic        out_imem_req;
    logic [63:0] out_imem_addr;
    logic        in_imem_gnt, in_imem_rvalid;
    logic [31:0] in_imem_rdata;
    logic [31:0] out_fetch_insnbits;
    logic [63:0] out_fetch_pc;
    logic        out_fetch_done, out_halted;

    fetch_queue_unit #(
        .FQ_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RST_PC)
    ) dut (
        .in_clk             (in_clk),
        .in_rst_n           (in_rst_n),
        .in_stall           (in_stall),
        .in_redirect_valid  (in_redirect_valid),
        .in_redirect_pc     (in_redirect_pc),
        .out_imem_req       (out_imem_req),
        .out_imem_addr      (out_imem_addr),
        .in_imem_gnt        (in_imem_gnt),
        .in_imem_rvalid     (in_imem_rvalid),
        .in_imem_rdata      (in_imem_rdata),
        .out_fetch_insnbits (out_fetch_insnbits),
        .out_fetch_pc       (out_fetch_pc),
        .out_fetch_done     (out_fetch_done),
        .out_halted         (out_halted)
    );

    always #5 in_clk = ~in_clk;

    typedef struct { logic [63:0] addr; int epoch; logic [31:0] word; int due; } req_t;
    typedef struct { logic [63:0] pc; logic [31:0] insn; } exp_t;

    req_t        pending[$];   // requests granted, response not yet returned
    exp_t        exp_q[$];     // words the DUT must deliver, in order
    int          epoch, cyc, last_due;
    logic [63:0] model_pc;
    bit          halted_m, running;
    int          lat_min, lat_max, rsp_pct, hlt_pct;
    logic [63:0] hlt_addr;
    int          n_checks, n_errors;

    function automatic bit word_is_hlt(input logic [31:0] w);
        return (w[31:21] == 11'b11010100010) && (w[4:0] == 5'b0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, want);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        exp_q.delete();
        epoch++;
        model_pc = RST_PC;
        halted_m = 1'b0;
    endtask

    // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cycle(input bit stall, input bit gnt, input bit redir,
                         input logic [63:0] rpc, output bit done_s, output logic [63:0] dpc);
        bit   rv, req_s;
        req_t p;
        int   d;
        rv = (pending.size() > 0) && (pending[0].due <= cyc) &&
             ($urandom_range(0, 99) < rsp_pct);
        in_stall          = stall;
        in_imem_gnt       = gnt;
        in_redirect_valid = redir;
        in_redirect_pc    = rpc;
        in_imem_rvalid    = rv;
        in_imem_rdata     = rv ? pending[0].word : $urandom();
        @(negedge in_clk);
        req_s  = out_imem_req;
        done_s = out_fetch_done;
        dpc    = out_fetch_pc;
        @(posedge in_clk);
        if (rv) begin
            p = pending.pop_front();
            if (!redir && p.epoch == epoch && !halted_m) begin
                exp_q.push_back('{pc: p.addr, insn: p.word});
                if (word_is_hlt(p.word)) halted_m = 1'b1;
            end
        end
        if (req_s && gnt) begin
            p.addr  = model_pc;
            p.epoch = epoch;
            if (model_pc == hlt_addr || (hlt_pct > 0 && $urandom_range(0, 99) < hlt_pct))
                p.word = HLT_W;
            else
                p.word = $urandom() | 32'h1;
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            p.due = d;
            pending.push_back(p);
            model_pc = model_pc + 64'd4;
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            model_pc = {rpc[63:2], 2'b00};
            halted_m = 1'b0;
        end
        cyc++;
        #1;
    endtask

    // ---------------- Monitor / scoreboard ----------------
    always @(negedge in_clk) begin
        bit e_req, e_done;
        if (running && in_rst_n) begin
            e_req  = !halted_m && !in_redirect_valid && (pending.size() < MAX_OUT) &&
                     ((exp_q.size() + pending.size()) < DEPTH);
            e_done = (exp_q.size() > 0) && !in_stall && !in_redirect_valid;
            check("imem_req", out_imem_req, e_req);
            check("imem_addr", out_imem_addr, model_pc);
            check("halted", out_halted, halted_m);
            check("fetch_done", out_fetch_done, e_done);
            if (exp_q.size() > 0) begin
                check("head_pc", out_fetch_pc, exp_q[0].pc);
                check("head_insn", out_fetch_insnbits, exp_q[0].insn);
                if (out_fetch_done) void'(exp_q.pop_front());
            end else begin
                check("empty_pc", out_fetch_pc, 64'h0);
                check("empty_insn", out_fetch_insnbits, 32'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          d, found;
        logic [63:0] dpc;
        int          n;
        n_checks = 0; n_errors = 0; cyc = 0; epoch = 0; last_due = 0;
        running = 1'b0;
        lat_min = 1; lat_max = 1; rsp_pct = 100; hlt_pct = 0; hlt_addr = '1;
        in_rst_n = 1'b0; in_stall = 1'b0; in_redirect_valid = 1'b0; in_redirect_pc = '0;
        in_imem_gnt = 1'b0; in_imem_rvalid = 1'b0; in_imem_rdata = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_done", out_fetch_done, 0);
        check("rst_req", out_imem_req, 0);
        check("rst_addr", out_imem_addr, RST_PC);
        check("rst_halted", out_halted, 0);
        check("rst_insn", out_fetch_insnbits, 0);
        check("rst_pc", out_fetch_pc, 0);
        @(posedge in_clk); #1;
        in_rst_n = 1'b1;
        running  = 1'b1;

        // Streaming, 1-cycle latency
        repeat (20) cycle(0, 1, 0, '0, d, dpc);

        // Stall fills the queue, then drains back to back
        repeat (10) cycle(1, 1, 0, '0, d, dpc);
        check("stall_req_low", out_imem_req, 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, '0, d, dpc);
            n += int'(d);
        end
        check("stall_drain_dones", n, 4);

        // Two stale requests in flight, redirect to an unaligned PC
        lat_min = 4; lat_max = 4;
        cycle(0, 1, 1, 64'h2000, d, dpc);
        check("redir_addr_2000", out_imem_addr, 64'h2000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pending.size() == 2 && pending[0].addr == 64'h2000 && pending[0].due > cyc)
                found = 1;
            else
                cycle(0, 1, 0, '0, d, dpc);
        end
        check("two_outstanding_found", found, 1);
        cycle(0, 1, 1, 64'h3002, d, dpc);
        check("redir_addr_3000", out_imem_addr, 64'h3000);
        lat_min = 1; lat_max = 1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0, '0, d, dpc);
            if (d && !found) begin
                check("first_pc_3000", dpc, 64'h3000);
                found = 1;
            end
        end
        check("first_after_redirect_seen", found, 1);

        // Redirect coincident with a response, two outstanding
        lat_min = 2; lat_max = 2;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pending.size() == 2 && pending[0].due <= cyc) found = 1;
            else cycle(0, 1, 0, '0, d, dpc);
        end
        check("rv_redirect_setup", found, 1);
        cycle(0, 1, 1, 64'h500, d, dpc);
        check("redir_rv_no_done", d, 0);
        repeat (15) cycle(0, 1, 0, '0, d, dpc);

        // HLT at 0x40
        lat_min = 2; lat_max = 3; hlt_addr = 64'h40;
        cycle(0, 1, 1, 64'h40, d, dpc);
        repeat (25) cycle(0, 1, 0, '0, d, dpc);
        check("hlt_halted", out_halted, 1);
        check("hlt_req_low", out_imem_req, 0);
        hlt_addr = '1;
        cycle(0, 1, 1, 64'h80, d, dpc);
        check("resume_halted", out_halted, 0);
        check("resume_addr", out_imem_addr, 64'h80);
        repeat (15) cycle(0, 1, 0, '0, d, dpc);

        // Randomized traffic
        lat_min = 1; lat_max = 3; rsp_pct = 70; hlt_pct = 3;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 40) == 0), 64'($urandom_range(0, 4095)), d, dpc);
        end

        // Reset mid-stream with three queued entries
        lat_min = 1; lat_max = 1; rsp_pct = 100; hlt_pct = 0;
        cycle(0, 1, 1, 64'h700, d, dpc);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (exp_q.size() == 3) found = 1;
            else cycle(1, 1, 0, '0, d, dpc);
        end
        check("three_queued", found, 1);
        #2;
        in_rst_n = 1'b0;
        in_imem_rvalid = 1'b0; in_redirect_valid = 1'b0; in_stall = 1'b0;
        model_reset();
        #1;
        check("midrst_done", out_fetch_done, 0);
        check("midrst_req", out_imem_req, 0);
        check("midrst_addr", out_imem_addr, RST_PC);
        check("midrst_halted", out_halted, 0);
        @(posedge in_clk); #1;
        in_rst_n = 1'b1;
        repeat (20) cycle(0, 1, 0, '0, d, dpc);

        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Front-end fetch stage. Drives `PC`, issues word requests to instruction memory and buffers returned instruction words in a small FIFO.
- Presents one instruction per cycle to dispatch on the `insnbits`/`done` interface that dispatch consumes; dispatch latches on the `done` pulse.
- Handles branch redirects by flushing the queue and dropping in-flight stale responses.
- Stops fetching once an `HLT` word has been enqueued.

Parameters:
- `FQ_DEPTH`, 4, fetch queue entries (power of 2, ≥2).
- `MAX_OUTSTANDING`, 2, max imem requests granted but not yet responded (≥1).
- `RESET_PC`, 64'h0, `PC` loaded on reset.

Ports:
- `in_clk`  input  1  clock, rising edge.
- `in_rst_n`  input  1  asynchronous active-low reset.
- `in_stall`  input  1  dispatch/core stall; no instruction delivered this cycle.
- `in_redirect_valid`  input  1  branch resolution redirect strobe.
- `in_redirect_pc`  input  64  new fetch `PC`; bits [1:0] ignored (treated 0).
- `out_imem_req`  output  1  request valid.
- `out_imem_addr`  output  64  word address of request (`PC`).
- `in_imem_gnt`  input  1  request accepted this cycle (meaningful only when `out_imem_req`).
- `in_imem_rvalid`  input  1  response valid; responses return in request order, ≥1 cycle after grant.
- `in_imem_rdata`  input  32  instruction word.
- `out_fetch_insnbits`  output  32  head instruction word.
- `out_fetch_pc`  output  64  `PC` of head instruction.
- `out_fetch_done`  output  1  delivery strobe, one instruction per asserted cycle.
- `out_halted`  output  1  `HLT` enqueued; fetching stopped.

Behaviour:
- Reset (async, `in_rst_n`=0):
  - `PC`=`RESET_PC`; queue empty; outstanding=0; drop count=0; state=RUN.
  - All outputs 0, except `out_imem_addr`=`RESET_PC`.
- State machine RUN/HALTED:
  - RUN→HALTED when an accepted response word matches the `HLT` pattern (bits[31:21]=11010100010, bits[4:0]=0) and is enqueued.
  - HALTED→RUN only on `in_redirect_valid`.
- Request issue: `out_imem_req`=1 iff all of:
  - state=RUN;
  - no redirect this cycle;
  - outstanding < `MAX_OUTSTANDING`;
  - (queue count + outstanding) < `FQ_DEPTH` (credit rule: every response always has a slot).
- Request handshake:
  - `out_imem_addr`=`PC` combinationally.
  - On `out_imem_req` & `in_imem_gnt`: `PC`+=4 (mod 2^64 wrap), outstanding+=1.
  - `out_imem_req` may drop without a grant; no hold requirement.
- Response:
  - `in_imem_rvalid` decrements outstanding.
  - If drop count>0: word discarded, drop count−=1.
  - Else if state=HALTED: word discarded.
  - Else: enqueue {word, `PC` of that request}. A response-side `PC` counter advances by 4 per accepted response and is reloaded on redirect/reset.
- Simultaneous grant and response in one cycle: outstanding unchanged.
- Delivery:
  - `out_fetch_done` = queue non-empty & ~`in_stall` & ~`in_redirect_valid`; entry popped that cycle.
  - `out_fetch_insnbits`/`out_fetch_pc` show the queue head, or 0 when empty.
  - Combinational, zero-cycle queue read latency; a word written cycle N is deliverable no earlier than cycle N+1 (no bypass).
- Push and pop in the same cycle: allowed, including when the queue is full (pop frees the slot first).
- Redirect (`in_redirect_valid`=1) takes priority over all other events that cycle:
  - Queue flushed; `PC`=response `PC`=`in_redirect_pc` & ~3; state=RUN.
  - drop count = outstanding after this cycle's updates, i.e. includes a response arriving the same cycle? No — a response arriving this cycle is itself discarded. drop count = outstanding_before − (rvalid ? 1 : 0).
  - No request issued and no delivery in the redirect cycle.
- Back-to-back redirects: each recomputes drop count from the current outstanding count.
- Reset mid-operation: all in-flight responses are forgotten. Imem is reset alongside, so no drops are carried over.

Decomposition:
- Shared package additions:
  - `` `PC_SIZE``=64.
  - `` `INSNBITS_SIZE`` (existing).
  - `` `HLT_MASK``/`` `HLT_MATCH`` constants.
  - `fetch_state_t` enum {`FETCH_RUN`, `FETCH_HALTED`}.
- One sub-module: `fetch_fifo`, parameterized depth, width=96 ({pc, insn}). Ports: push, pop, flush; outputs head, count, empty, full.

Test Plan:
- Reset, `RESET_PC`=0x1000, `gnt`=1, 1-cycle response latency, `in_stall`=0 → requests to 0x1000, 0x1004, 0x1008; `done` pulses in order with `out_fetch_pc` matching each.
- `in_stall`=1 for 10 cycles with `gnt` always 1 → queue fills to 4, `out_imem_req` falls, count+outstanding never exceeds 4, no words lost; stall released → 4 consecutive `done` cycles.
- Two requests outstanding (0x2000, 0x2004), redirect to 0x3002 → both stale responses dropped; next request is 0x3000; first delivered PC=0x3000.
- Redirect in the same cycle as `rvalid` with outstanding=2 → that word dropped, drop count=1; `done`=0 that cycle.
- Response word 0xD4400000 (`HLT`) at PC 0x40 → enqueued and delivered; `out_halted`=1; `out_imem_req` stays 0; later responses discarded; redirect to 0x80 resumes fetch.
- Assert `in_rst_n`=0 mid-stream with queue holding 3 entries → immediate `done`=0, `req`=0, `addr`=`RESET_PC`, `out_halted`=0.
